// File: rtl/ecsu_sensor_scheduler.sv
// Round-robin poller for the four ECSU weather sensors with timeout/retry fault detection.
// Define ECSU_FAILSAFE_EN to load worst-case values into a channel's shadow when it faults.
module ecsu_sensor_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned NUM_RETRY      = 2,
  parameter int unsigned POLL_INTERVAL  = 100
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              enable,
  output logic              sens_req,
  output logic [1:0]        sens_sel,
  input  logic              sens_ack,
  input  logic [7:0]        sens_data,
  output logic              thunderstorm,
  output logic [5:0]        wind,
  output logic [1:0]        visibility,
  output logic signed [7:0] temperature,
  output logic              snapshot_valid,
  output logic [3:0]        sensor_fault,
  output logic [2:0]        sched_state
);

  typedef enum logic [2:0] {
    S_IDLE          = 3'd0,
    S_REQUEST       = 3'd1,
    S_WAIT_ACK      = 3'd2,
    S_COMMIT        = 3'd3,
    S_WAIT_INTERVAL = 3'd4
  } state_t;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned PW = $clog2(POLL_INTERVAL + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_INTERVAL - 1);
  localparam logic [PW-1:0] POLL_ONE  = PW'(1);
  localparam logic [2:0]    RETRY_MAX = 3'(NUM_RETRY);

  state_t             r_state;
  logic [1:0]         r_ch;
  logic [TW-1:0]      r_tmo;
  logic [2:0]         r_retry;
  logic [PW-1:0]      r_poll;
  logic               r_req;
  logic [1:0]         r_sel;
  logic               r_sh_ts;
  logic [5:0]         r_sh_wind;
  logic [1:0]         r_sh_vis;
  logic signed [7:0]  r_sh_temp;
  logic [3:0]         r_pend;
  logic               r_ts;
  logic [5:0]         r_wind;
  logic [1:0]         r_vis;
  logic signed [7:0]  r_temp;
  logic               r_valid;
  logic [3:0]         r_fault;

  logic w_expire;
  logic w_final;
  logic w_done;

  assign w_expire = (r_tmo == TMO_LAST);
  assign w_final  = w_expire && (r_retry == RETRY_MAX);
  // An ack coinciding with expiry wins, so the channel is done on either event.
  assign w_done   = sens_ack || w_final;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_ch      <= '0;
      r_tmo     <= '0;
      r_retry   <= '0;
      r_poll    <= '0;
      r_req     <= 1'b0;
      r_sel     <= '0;
      r_sh_ts   <= 1'b0;
      r_sh_wind <= '0;
      r_sh_vis  <= '0;
      r_sh_temp <= '0;
      r_pend    <= '0;
      r_ts      <= 1'b0;
      r_wind    <= '0;
      r_vis     <= '0;
      r_temp    <= '0;
      r_valid   <= 1'b0;
      r_fault   <= '0;
    end else begin
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_ch    <= '0;
            r_state <= S_REQUEST;
          end
        end
        S_REQUEST: begin
          r_sel   <= r_ch;
          r_tmo   <= '0;
          r_req   <= 1'b1;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (w_done) begin
            r_retry <= '0;
            if (sens_ack) begin
              r_pend[r_ch] <= 1'b0;
              case (r_ch)
                2'd0:    r_sh_ts   <= sens_data[0];
                2'd1:    r_sh_wind <= sens_data[5:0];
                2'd2:    r_sh_vis  <= sens_data[1:0];
                default: r_sh_temp <= sens_data;
              endcase
            end else begin
              r_pend[r_ch] <= 1'b1;
`ifdef ECSU_FAILSAFE_EN
              case (r_ch)
                2'd0:    r_sh_ts   <= 1'b1;
                2'd1:    r_sh_wind <= '1;
                2'd2:    r_sh_vis  <= '1;
                default: r_sh_temp <= 8'sd127;
              endcase
`else
`endif
            end
            // Losing enable lets the current channel finish but skips the commit.
            if (!enable) begin
              r_state <= S_IDLE;
            end else if (r_ch == 2'd3) begin
              r_state <= S_COMMIT;
            end else begin
              r_ch    <= r_ch + 2'd1;
              r_state <= S_REQUEST;
            end
          end else if (w_expire) begin
            r_retry <= r_retry + 3'd1;
            r_state <= S_REQUEST;
          end else begin
            r_tmo <= r_tmo + TMO_ONE;
            r_req <= 1'b1;
          end
        end
        S_COMMIT: begin
          r_ts    <= r_sh_ts;
          r_wind  <= r_sh_wind;
          r_vis   <= r_sh_vis;
          r_temp  <= r_sh_temp;
          r_fault <= r_pend;
          r_valid <= 1'b1;
          r_poll  <= '0;
          r_state <= S_WAIT_INTERVAL;
        end
        S_WAIT_INTERVAL: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (r_poll == POLL_LAST) begin
            r_ch    <= '0;
            r_state <= S_REQUEST;
          end else begin
            r_poll <= r_poll + POLL_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sens_req       = r_req;
  assign sens_sel       = r_sel;
  assign thunderstorm   = r_ts;
  assign wind           = r_wind;
  assign visibility     = r_vis;
  assign temperature    = r_temp;
  assign snapshot_valid = r_valid;
  assign sensor_fault   = r_fault;
  assign sched_state    = r_state;

endmodule

// File: tb/tb_ecsu_sensor_scheduler.sv
// Self-checking bench for ecsu_sensor_scheduler: table vectors, hand-written corner
// sequences and randomized sweeps checked against a transaction-level sweep model.
module tb_ecsu_sensor_scheduler;
  localparam int T  = 16;
  localparam int NR = 2;
  localparam int PI = 100;
`ifdef ECSU_FAILSAFE_EN
  localparam bit FS = 1'b1;
`else
  localparam bit FS = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST_N = 1'b1;
  logic              enable = 1'b0;
  logic              sens_ack;
  logic [7:0]        sens_data;
  logic              sens_req;
  logic [1:0]        sens_sel;
  logic              thunderstorm;
  logic [5:0]        wind;
  logic [1:0]        visibility;
  logic signed [7:0] temperature;
  logic              snapshot_valid;
  logic [3:0]        sensor_fault;
  logic [2:0]        sched_state;

  ecsu_sensor_scheduler #(.TIMEOUT_CYCLES(T), .NUM_RETRY(NR), .POLL_INTERVAL(PI)) dut (
    .CLK(CLK), .RST_N(RST_N), .enable(enable),
    .sens_req(sens_req), .sens_sel(sens_sel), .sens_ack(sens_ack), .sens_data(sens_data),
    .thunderstorm(thunderstorm), .wind(wind), .visibility(visibility),
    .temperature(temperature), .snapshot_valid(snapshot_valid),
    .sensor_fault(sensor_fault), .sched_state(sched_state)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  // Sensor behaviour per channel: attempts that never ack, then ack on WAIT_ACK cycle dly.
  int fail_att [4];
  int dly      [4];
  int dat      [4];
  bit spurious = 1'b0;
  int resp_gen = 0;
  int req_cyc  [4];
  int bursts   [4];
  int first_sel = -1;
  int seen_gen = 0;
  int last_sel = -1;
  int att = 0;
  int k = 0;
  bit prev_req = 1'b0;

  always @(negedge CLK) begin
    int ch;
    if (resp_gen != seen_gen) begin
      seen_gen = resp_gen; last_sel = -1; att = 0; k = 0; first_sel = -1;
      for (int c = 0; c < 4; c++) begin req_cyc[c] = 0; bursts[c] = 0; end
    end
    if (sens_req) begin
      ch = int'(sens_sel);
      if (!prev_req) begin
        if (ch == last_sel) att++;
        else begin att = 0; last_sel = ch; end
        if (first_sel < 0) first_sel = ch;
        bursts[ch]++;
        k = 1;
      end else k++;
      req_cyc[ch]++;
      if (att >= fail_att[ch] && k == dly[ch]) begin
        sens_ack = 1'b1; sens_data = 8'(dat[ch]);
      end else begin
        sens_ack = 1'b0; sens_data = 8'($urandom);
      end
    end else begin
      sens_ack  = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      sens_data = 8'($urandom);
    end
    prev_req = sens_req;
  end

  // Reference model: shadow values, committed outputs and expected bus activity.
  int m_sh  [4];
  int m_out [4];
  int m_fault = 0;
  int e_bursts [4];
  int e_req    [4];

  function automatic int extract(input int ch, input int d);
    case (ch)
      0:       return d % 2;
      1:       return d % 64;
      2:       return d % 4;
      default: return (d > 127) ? d - 256 : d;
    endcase
  endfunction

  function automatic int worst(input int ch);
    case (ch)
      0:       return 1;
      1:       return 63;
      2:       return 3;
      default: return 127;
    endcase
  endfunction

  task automatic model_sweep(output int lat);
    int cyc = 0;
    int faults = 0;
    for (int ch = 0; ch < 4; ch++) begin
      if (fail_att[ch] > NR) begin
        faults |= (1 << ch);
        if (FS) m_sh[ch] = worst(ch);
        cyc += (NR + 1) * (T + 1);
        e_bursts[ch] = NR + 1;
        e_req[ch]    = (NR + 1) * T;
      end else begin
        m_sh[ch] = extract(ch, dat[ch]);
        cyc += fail_att[ch] * (T + 1) + 1 + dly[ch];
        e_bursts[ch] = fail_att[ch] + 1;
        e_req[ch]    = fail_att[ch] * T + dly[ch];
      end
    end
    for (int ch = 0; ch < 4; ch++) m_out[ch] = m_sh[ch];
    m_fault = faults;
    lat = cyc + 2;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model_outputs(input string tag);
    chk({tag, " thunderstorm"}, thunderstorm, m_out[0]);
    chk({tag, " wind"}, wind, m_out[1]);
    chk({tag, " visibility"}, visibility, m_out[2]);
    chk({tag, " temperature"}, temperature, m_out[3]);
    chk({tag, " sensor_fault"}, sensor_fault, m_fault);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " sens_req"}, sens_req, 0);
    chk({tag, " sens_sel"}, sens_sel, 0);
    chk({tag, " thunderstorm"}, thunderstorm, 0);
    chk({tag, " wind"}, wind, 0);
    chk({tag, " visibility"}, visibility, 0);
    chk({tag, " temperature"}, temperature, 0);
    chk({tag, " snapshot_valid"}, snapshot_valid, 0);
    chk({tag, " sensor_fault"}, sensor_fault, 0);
    chk({tag, " sched_state"}, sched_state, 0);
  endtask

  task automatic run_sweep(input string tag, output int got);
    int lat;
    got = 0;
    resp_gen++;
    model_sweep(lat);
    @(negedge CLK);
    enable = 1'b1;
    for (int e = 1; e <= 2000; e++) begin
      @(posedge CLK); #1;
      if (snapshot_valid) begin got = e; break; end
    end
    chk({tag, " latency"}, got, lat);
    check_model_outputs(tag);
    chk({tag, " state after commit"}, sched_state, 4);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("%s ch%0d bursts", tag, c), bursts[c], e_bursts[c]);
      chk($sformatf("%s ch%0d req cycles", tag, c), req_cyc[c], e_req[c]);
    end
    @(posedge CLK); #1;
    chk({tag, " valid width"}, snapshot_valid, 0);
    enable = 1'b0;
    @(posedge CLK); #1;
    chk({tag, " idle after disable"}, sched_state, 0);
  endtask

  task automatic set_cfg(input logic [11:0] f, input logic [19:0] d, input logic [31:0] v);
    logic [3:0][2:0] fa;
    logic [3:0][4:0] dl;
    logic [3:0][7:0] dt;
    fa = f; dl = d; dt = v;
    for (int c = 0; c < 4; c++) begin
      fail_att[c] = int'(fa[c]); dly[c] = int'(dl[c]); dat[c] = int'(dt[c]);
    end
  endtask

  // Packed fields list channel 3 first (MSB) down to channel 0.
  typedef struct {
    logic [11:0] fail;
    logic [19:0] dl;
    logic [31:0] dt;
    int e_ts, e_wind, e_vis, e_temp, e_fault, e_lat;
  } vec_t;

  function automatic vec_t mk(input logic [11:0] f, input logic [19:0] d, input logic [31:0] v,
                              input int ts, input int w, input int vis, input int tp,
                              input int flt, input int lat);
    vec_t r;
    r.fail = f; r.dl = d; r.dt = v;
    r.e_ts = ts; r.e_wind = w; r.e_vis = vis; r.e_temp = tp; r.e_fault = flt; r.e_lat = lat;
    return r;
  endfunction

  vec_t tbl [6];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int got, e1, e2, found, saw_valid, idle_at;
    for (int c = 0; c < 4; c++) begin
      m_sh[c] = 0; m_out[c] = 0; fail_att[c] = 0; dly[c] = 1; dat[c] = 0;
    end

    tbl[0] = mk({3'd0,3'd0,3'd0,3'd0}, {5'd1,5'd1,5'd1,5'd1}, 32'hDA010C01, 1, 12, 1, -38, 0, 10);
    tbl[1] = mk({3'd0,3'd0,3'd3,3'd0}, {5'd1,5'd1,5'd1,5'd1}, 32'hDA010C01, 1, FS ? 63 : 12, 1, -38, 2, 59);
    tbl[2] = mk({3'd0,3'd0,3'd0,3'd0}, {5'd16,5'd1,5'd1,5'd1}, 32'h28022100, 0, 33, 2, 40, 0, 25);
    tbl[3] = mk({3'd0,3'd0,3'd0,3'd0}, {5'd1,5'd2,5'd1,5'd3}, 32'h80FEFFFE, 0, 63, 2, -128, 0, 13);
    tbl[4] = mk({3'd3,3'd1,3'd0,3'd2}, {5'd1,5'd16,5'd5,5'd1}, 32'h11074003, 1, 0, 3, FS ? 127 : -128, 8, 129);
    tbl[5] = mk({3'd0,3'd0,3'd0,3'd0}, {5'd1,5'd1,5'd1,5'd1}, 32'hDA010C01, 1, 12, 1, -38, 0, 10);

    #3 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1 check_zero("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 6; i++) begin
      set_cfg(tbl[i].fail, tbl[i].dl, tbl[i].dt);
      run_sweep($sformatf("vec%0d", i), got);
      chk($sformatf("vec%0d table latency", i), got, tbl[i].e_lat);
      chk($sformatf("vec%0d table thunderstorm", i), thunderstorm, tbl[i].e_ts);
      chk($sformatf("vec%0d table wind", i), wind, tbl[i].e_wind);
      chk($sformatf("vec%0d table visibility", i), visibility, tbl[i].e_vis);
      chk($sformatf("vec%0d table temperature", i), temperature, tbl[i].e_temp);
      chk($sformatf("vec%0d table fault", i), sensor_fault, tbl[i].e_fault);
    end

    // Back-to-back sweeps with enable held high.
    set_cfg({3'd0,3'd0,3'd0,3'd0}, {5'd1,5'd1,5'd1,5'd1}, 32'h5A024501);
    resp_gen++;
    model_sweep(got);
    e1 = 0; e2 = 0;
    @(negedge CLK);
    enable = 1'b1;
    for (int e = 1; e <= 600; e++) begin
      @(posedge CLK); #1;
      if (snapshot_valid) begin
        if (e1 == 0) e1 = e;
        else begin e2 = e; break; end
      end
    end
    chk("interval first latency", e1, got);
    chk("interval pulse spacing", e2 - e1, PI + 8 + 1);
    check_model_outputs("interval");
    enable = 1'b0;
    repeat (2) @(posedge CLK);
    #1 chk("interval idle", sched_state, 0);

    // enable dropped while channel 2 waits; its ack arrives on the 4th WAIT_ACK cycle.
    set_cfg({3'd0,3'd0,3'd0,3'd0}, {5'd1,5'd4,5'd1,5'd1}, 32'h55032A00);
    resp_gen++;
    @(negedge CLK);
    enable = 1'b1;
    found = 0;
    for (int e = 0; e < 100; e++) begin
      @(negedge CLK);
      if (sens_req && sens_sel == 2'd2) begin found = 1; break; end
    end
    chk("abort reached ch2", found, 1);
    enable = 1'b0;
    saw_valid = 0; idle_at = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge CLK); #1;
      if (snapshot_valid) saw_valid = 1;
      if (sched_state == 3'd0 && idle_at == 0) idle_at = e;
    end
    chk("abort no snapshot", saw_valid, 0);
    chk("abort idle edge", idle_at, 4);
    check_model_outputs("abort hold");
    for (int c = 0; c < 3; c++) m_sh[c] = extract(c, dat[c]);
    set_cfg({3'd0,3'd0,3'd3,3'd3}, {5'd1,5'd1,5'd1,5'd1}, 32'h01010101);
    run_sweep("post-abort", got);

    // Asynchronous reset while channel 3 is waiting.
    set_cfg({3'd3,3'd0,3'd0,3'd0}, {5'd1,5'd1,5'd1,5'd1}, 32'h33221101);
    resp_gen++;
    @(negedge CLK);
    enable = 1'b1;
    found = 0;
    for (int e = 0; e < 100; e++) begin
      @(negedge CLK);
      if (sens_req && sens_sel == 2'd3) begin found = 1; break; end
    end
    chk("reset reached ch3", found, 1);
    #2 RST_N = 1'b0;
    #1 check_zero("mid-sweep reset");
    enable = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int c = 0; c < 4; c++) begin m_sh[c] = 0; m_out[c] = 0; end
    m_fault = 0;
    set_cfg({3'd0,3'd0,3'd3,3'd0}, {5'd1,5'd1,5'd1,5'd1}, 32'h7F023F01);
    run_sweep("post-reset", got);
    chk("post-reset first channel", first_sel, 0);

    // Randomized sweeps with stray acks outside WAIT_ACK.
    spurious = 1'b1;
    for (int s = 0; s < 12; s++) begin
      for (int c = 0; c < 4; c++) begin
        int r;
        r = int'($urandom_range(0, 9));
        fail_att[c] = (r < 6) ? 0 : (r < 8) ? int'($urandom_range(1, NR)) : NR + 1;
        dly[c] = ($urandom_range(0, 3) == 0) ? T : int'($urandom_range(1, T));
        dat[c] = int'($urandom_range(0, 255));
      end
      run_sweep($sformatf("rand%0d", s), got);
    end
    spurious = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ecsu_sensor_scheduler.md
Name: ecsu_sensor_scheduler

Overview:
- Polls the four environmental sensors (thunderstorm, wind, visibility, temperature) over one shared request/acknowledge sensor bus, in round-robin order.
- Assembles the results into a coherent snapshot and drives the ECSU weather inputs, updating all four together with a one-cycle strobe.
- Detects non-responding sensors with timeout and retry, and reports per-channel fault flags.

Parameters:
- TIMEOUT_CYCLES, 16: WAIT_ACK cycles without ack before one attempt is declared failed (≥2).
- NUM_RETRY, 2: extra attempts per channel after the first failed attempt (0..7).
- POLL_INTERVAL, 100: idle cycles between the end of one sweep and the start of the next (≥1).

Ports:
- CLK, input, 1: system clock; all state changes on its rising edge.
- RST_N, input, 1: reset, asynchronous, active-low. One clock; no other clocks.
- enable, input, 1: allows sweeps to run.
- sens_req, output, 1: bus request to the selected sensor.
- sens_sel, output, 2: selected channel. 0=thunderstorm, 1=wind, 2=visibility, 3=temperature.
- sens_ack, input, 1: sensor acknowledge; sens_data is valid in the same cycle.
- sens_data, input, 8: sensor payload.
- thunderstorm, output, 1: snapshot value for the ECSU.
- wind, output, 6: snapshot value for the ECSU.
- visibility, output, 2: snapshot value for the ECSU.
- temperature, output, 8 signed: snapshot value for the ECSU.
- snapshot_valid, output, 1: one-cycle pulse when the snapshot outputs update.
- sensor_fault, output, 4: per-channel fault flags; bit index = channel.
- sched_state, output, 3: current FSM state encoding, for debug.

Behaviour:
- Reset (RST_N low, asynchronous):
  - FSM to IDLE; channel, timeout and retry counters cleared.
  - All outputs 0: sens_req, sens_sel, snapshot outputs, snapshot_valid, sensor_fault, sched_state.
  - Shadow registers cleared.
  - Reset asserted mid-sweep aborts the sweep; no commit occurs.
- States (sched_state encoding): IDLE=0, REQUEST=1, WAIT_ACK=2, COMMIT=3, WAIT_INTERVAL=4.
- IDLE:
  - Goes to REQUEST with channel 0 when enable=1; otherwise stays in IDLE.
  - Snapshot outputs hold their values.
- REQUEST:
  - One cycle; sens_req=0.
  - sens_sel is loaded with the current channel; timeout counter cleared.
  - Always goes to WAIT_ACK.
- WAIT_ACK:
  - sens_req=1; sens_sel stays stable.
  - sens_ack=1: capture sens_data into the channel shadow register and reset the retry counter.
    - Channel 0 takes bit[0]; channel 1 takes [5:0]; channel 2 takes [1:0]; channel 3 takes [7:0] as two's complement.
    - Clear the channel's pending-fault bit.
    - Advance: channel<3 goes to REQUEST for channel+1; channel 3 goes to COMMIT.
  - sens_ack=0: increment the timeout counter.
    - When the counter reaches TIMEOUT_CYCLES-1 with retry<NUM_RETRY: retry++, go to REQUEST for the same channel.
    - When the counter reaches TIMEOUT_CYCLES-1 with retry==NUM_RETRY: set the pending-fault bit, leave the shadow register unchanged, reset retry, and advance as for an ack.
  - An ack in the same cycle as a timeout expiry counts as an ack.
  - sens_ack outside WAIT_ACK is ignored.
- COMMIT:
  - One cycle; sens_req=0.
  - On the exit edge, all four shadow registers copy to the snapshot outputs, sensor_fault takes the pending-fault vector, and snapshot_valid=1 for exactly the next cycle.
  - Always goes to WAIT_INTERVAL.
- WAIT_INTERVAL:
  - Counts POLL_INTERVAL cycles.
  - At expiry: goes to REQUEST channel 0 if enable=1, else IDLE.
  - enable=0 at any point in this state goes to IDLE at the next edge.
- enable falling mid-sweep:
  - The current channel transaction finishes (ack or final fault) and the FSM goes to IDLE.
  - No COMMIT; snapshot outputs and sensor_fault hold.
- Latency, all acks on the first WAIT_ACK cycle:
  - Counting the edge that samples enable=1 in IDLE as edge 1, snapshot outputs and snapshot_valid change on edge 10.
  - Each timed-out attempt adds TIMEOUT_CYCLES+1 cycles.
- Fault flags clear only at a COMMIT following a successful ack on that channel.

Optional Feature:
- ECSU_FAILSAFE_EN defined: a channel declared faulted loads its shadow register with the worst-case value instead of holding the last good value. This forces the ECSU toward alert states. Worst-case values:
  - thunderstorm=1
  - wind=63
  - visibility=2'b11
  - temperature=+127
- ECSU_FAILSAFE_EN undefined: a faulted channel holds its last successfully captured value (0 after reset).

Test Plan:
1. Reset, enable=1, sensor model acks every request on the first WAIT_ACK cycle with data 0x01, 0x0C, 0x01, 0xDA → on edge 10, thunderstorm=1, wind=12, visibility=01, temperature=-38; snapshot_valid high for 1 cycle; sensor_fault=0000.
2. Wind sensor never acks, TIMEOUT_CYCLES=16, NUM_RETRY=2 → channel 1 sees 3 sens_req bursts of 16 cycles each; sensor_fault=0010 at commit; wind holds 12, or is 63 with ECSU_FAILSAFE_EN.
3. Temperature sensor acks on the 16th WAIT_ACK cycle, the same cycle as expiry → data 0x28 accepted; temperature=40; no retry; no fault.
4. enable dropped while channel 2 is in WAIT_ACK and ack arrives 3 cycles later → FSM goes to IDLE; no snapshot_valid; outputs unchanged.
5. RST_N pulsed low during WAIT_ACK of channel 3 → all outputs 0 immediately, sched_state=0; the next sweep starts from channel 0.
6. Two consecutive sweeps with POLL_INTERVAL=100 → the snapshot_valid pulses are exactly 109 cycles apart: 100 interval cycles + 8 sweep cycles + 1 COMMIT cycle.
